toggle_pulse_gen: RTL

Front-end stage that drives the T input of the t_ff toggle flip-flop from a raw, bouncy push-button.
- Synchronizes the asynchronous button into the clk domain and debounces both press and release.
- Emits exactly one single-cycle toggle strobe per accepted press, so the downstream t_ff flips q once per press.
- Also exports the debounced level and a press counter for status/LED use.

---
 rtl/toggle_pulse_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen: debounced push-button to single-cycle toggle strobe (drives t of t_ff)
// Ports: clk, reset (async active-high), btn_in (raw button), t_pulse (1-cycle strobe),
//        btn_level (debounced level), press_count (strobes issued, wraps).
// Optional: define TOGGLE_AUTO_REPEAT_EN to re-strobe every REPEAT_CYCLES while held.
module toggle_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 16,
  parameter int REPEAT_CYCLES = 8,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_in,
  output logic              t_pulse,
  output logic              btn_level,
  output logic [PCNT_W-1:0] press_count
);
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state_q, state_d;
  logic s1_q, btn_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pulse_q, pulse_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
`ifdef TOGGLE_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  logic [RW-1:0] rpt_q, rpt_d;
`else
  logic unused_rpt;
  assign unused_rpt = |REPEAT_CYCLES;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pulse_d = 1'b0;
`ifdef TOGGLE_AUTO_REPEAT_EN
    rpt_d = rpt_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = btn_s_q ? PRESS_CHK : IDLE;
        cnt_d = '0;
      end
      PRESS_CHK: begin
        if (!btn_s_q) state_d = IDLE;
        else if (cnt_q == LAST) begin
          state_d = HELD;
          pulse_d = 1'b1;
`ifdef TOGGLE_AUTO_REPEAT_EN
          rpt_d = '0;
`endif
        end else cnt_d = cnt_q + 1'b1;
      end
      HELD: begin
        if (!btn_s_q) begin
          state_d = RELEASE_CHK;
          cnt_d = '0;
        end
`ifdef TOGGLE_AUTO_REPEAT_EN
        // Repeat counter runs every HELD cycle and freezes outside HELD, so a
        // bounce through RELEASE_CHK resumes the spacing rather than restarting it.
        pulse_d = (rpt_q == RW'(REPEAT_CYCLES - 1));
        rpt_d = pulse_d ? '0 : rpt_q + 1'b1;
`endif
      end
      default: begin
        if (btn_s_q) state_d = HELD;
        else if (cnt_q == LAST) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
    endcase
    pcnt_d = pcnt_q + PCNT_W'(pulse_d);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      btn_s_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      pulse_q <= 1'b0;
      pcnt_q <= '0;
`ifdef TOGGLE_AUTO_REPEAT_EN
      rpt_q <= '0;
`endif
    end else begin
      s1_q <= btn_in;
      btn_s_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      pulse_q <= pulse_d;
      pcnt_q <= pcnt_d;
`ifdef TOGGLE_AUTO_REPEAT_EN
      rpt_q <= rpt_d;
`endif
    end
  end
  assign t_pulse = pulse_q;
  assign btn_level = (state_q == HELD) || (state_q == RELEASE_CHK);
  assign press_count = pcnt_q;
endmodule
